csr_hpm_counters: RTL and testbench

CSR_HPM_COUNTERS -- requirements
Module: csr_hpm_counters

---
 rtl/csr_hpm_counters_pkg.sv | 12 +
 rtl/csr_hpm_counters_if.sv | 25 ++
 rtl/csr_hpm_counters_hpm_counter.sv | 86 ++++++++
 rtl/csr_hpm_counters.sv | 111 +++++++++++
 tb/tb_csr_hpm_counters.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_hpm_counters_pkg.sv
// Shared constants and types for the hardware performance monitor counters.
// Holds the base CSR addresses and the 5-bit event selector type.
package csr_hpm_counters_pkg;

  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;

  typedef logic [4:0] hpm_sel;

endpackage

// File: rtl/csr_hpm_counters_if.sv
// CSR access bus of the HPM block: address, strobes, write data,
// registered read data/valid, decode hit and overflow interrupt.
interface csr_hpm_counters_if;
  import csr_hpm_counters_pkg::*;

  logic [11:0] add;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        hit;
  logic        ovf_irq;

  modport master (
    output add, rd, wr, wdata,
    input  rdata, rvalid, hit, ovf_irq
  );

  modport slave (
    input  add, rd, wr, wdata,
    output rdata, rvalid, hit, ovf_irq
  );

endinterface

// File: rtl/csr_hpm_counters_hpm_counter.sv
// One HPM counter: count, selector, optional sticky overflow (HPM_OVF_IRQ_EN).
// Ports: clk/rst, events, inhibit, per-half write enables, wdata, state out.
module hpm_counter
  import csr_hpm_counters_pkg::*;
#(
  parameter int CNT_WIDTH = 40,
  parameter int NUM_EVT   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               inh_i,
  input  logic               we_sel_i,
  input  logic               we_lo_i,
  input  logic               we_hi_i,
  input  logic [31:0]        wdata_i,
  output logic [63:0]        cnt_o,
  output hpm_sel             sel_o,
  output logic               ovf_o,
  output logic               ovf_d_o
);

  localparam int HW = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  hpm_sel               sel_q, sel_d;
  logic [31:0]          evt_map;
  logic                 inc;
  logic                 wrap;

  // Selector k picks event bit k-1; slot 0 and
  // slots above NUM_EVT are always zero.
  assign evt_map = 32'({evt_i, 1'b0});
  assign inc     = evt_map[sel_q] & ~inh_i;
  assign wrap    = inc & (&cnt_q) & ~we_lo_i & ~we_hi_i;

  always_comb begin
    cnt_d = cnt_q;
    if (we_lo_i)
      cnt_d[31:0] = wdata_i;
    else if (we_hi_i)
      cnt_d[CNT_WIDTH-1:32] = wdata_i[HW-1:0];
    else if (inc)
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  assign sel_d = we_sel_i ? hpm_sel'(wdata_i[4:0]) : sel_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

`ifdef HPM_OVF_IRQ_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | wrap;
    if (we_sel_i)
      ovf_d = wdata_i[31];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_o   = ovf_q;
  assign ovf_d_o = ovf_d;
`else
  assign ovf_o   = 1'b0;
  assign ovf_d_o = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{wdata_i, wrap};

  assign cnt_o = 64'(cnt_q);
  assign sel_o = sel_q;

endmodule

// File: rtl/csr_hpm_counters.sv
// HPM counter CSR block: mcountinhibit, mhpmevent/mhpmcounter(h) decode.
// Ports: s_clk_i, s_reset_i, s_event_i, CSR bus, s_ovf_irq_o (HPM_OVF_IRQ_EN).
module csr_hpm_counters
  import csr_hpm_counters_pkg::*;
#(
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 40,
  parameter int NUM_EVT   = 8
) (
  input  logic               s_clk_i,
  input  logic               s_reset_i,
  input  logic [NUM_EVT-1:0] s_event_i,
  input  logic [11:0]        s_csr_add_i,
  input  logic               s_csr_rd_i,
  input  logic               s_csr_wr_i,
  input  logic [31:0]        s_csr_wdata_i,
  output logic [31:0]        s_csr_rdata_o,
  output logic               s_csr_rvalid_o,
  output logic               s_csr_hit_o,
  output logic               s_ovf_irq_o
);

  logic [NUM_CNT-1:0] inh_q;
  logic [NUM_CNT-1:0] we_sel;
  logic [NUM_CNT-1:0] we_lo;
  logic [NUM_CNT-1:0] we_hi;
  logic [NUM_CNT-1:0] ovf;
  logic [NUM_CNT-1:0] ovf_d;
  logic [63:0]        cnt [NUM_CNT];
  hpm_sel             sel [NUM_CNT];

  logic [31:0] rd_data, rdata_q;
  logic        hit, rvalid_q, irq_q;
  logic        inh_we;

  assign inh_we = s_csr_wr_i &
    (s_csr_add_i == CSR_MCOUNTINHIBIT);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    assign we_sel[i] = s_csr_wr_i &
      (s_csr_add_i == CSR_MHPMEVENT3 + 12'(i));
    assign we_lo[i] = s_csr_wr_i &
      (s_csr_add_i == CSR_MHPMCOUNTER3 + 12'(i));
    assign we_hi[i] = s_csr_wr_i &
      (s_csr_add_i == CSR_MHPMCOUNTER3H + 12'(i));

    hpm_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .NUM_EVT   (NUM_EVT)
    ) u_cnt (
      .clk_i    (s_clk_i),
      .rst_i    (s_reset_i),
      .evt_i    (s_event_i),
      .inh_i    (inh_q[i]),
      .we_sel_i (we_sel[i]),
      .we_lo_i  (we_lo[i]),
      .we_hi_i  (we_hi[i]),
      .wdata_i  (s_csr_wdata_i),
      .cnt_o    (cnt[i]),
      .sel_o    (sel[i]),
      .ovf_o    (ovf[i]),
      .ovf_d_o  (ovf_d[i])
    );
  end

  always_comb begin
    rd_data = '0;
    hit     = 1'b0;
    if (s_csr_add_i == CSR_MCOUNTINHIBIT) begin
      hit     = 1'b1;
      rd_data = 32'({inh_q, 3'b000});
    end
    for (int i = 0; i < NUM_CNT; i++) begin
      if (s_csr_add_i == CSR_MHPMEVENT3 + 12'(i)) begin
        hit     = 1'b1;
        rd_data = {ovf[i], 26'b0, sel[i]};
      end
      if (s_csr_add_i == CSR_MHPMCOUNTER3 + 12'(i)) begin
        hit     = 1'b1;
        rd_data = cnt[i][31:0];
      end
      if (s_csr_add_i == CSR_MHPMCOUNTER3H + 12'(i)) begin
        hit     = 1'b1;
        rd_data = cnt[i][63:32];
      end
    end
  end

  // IRQ is registered from next-state overflow so it rises
  // in the same cycle the sticky bit becomes visible.
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      inh_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (inh_we)
        inh_q <= s_csr_wdata_i[3 +: NUM_CNT];
      rvalid_q <= s_csr_rd_i;
      rdata_q  <= s_csr_rd_i ? rd_data : 32'h0;
      irq_q    <= |ovf_d;
    end
  end

  assign s_csr_rdata_o  = rdata_q;
  assign s_csr_rvalid_o = rvalid_q;
  assign s_csr_hit_o    = hit;
  assign s_ovf_irq_o    = irq_q;

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Self-checking bench for csr_hpm_counters against a behavioural model.
// Directed scenarios plus randomized CSR/event traffic.
module tb_csr_hpm_counters;
  import csr_hpm_counters_pkg::*;

  localparam int NC = 4;
  localparam int CW = 40;
  localparam int NE = 8;
  localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

`ifdef HPM_OVF_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NE-1:0] ev  = '0;

  csr_hpm_counters_if bus ();

  always #5 clk = ~clk;

  csr_hpm_counters #(
    .NUM_CNT   (NC),
    .CNT_WIDTH (CW),
    .NUM_EVT   (NE)
  ) dut (
    .s_clk_i        (clk),
    .s_reset_i      (rst),
    .s_event_i      (ev),
    .s_csr_add_i    (bus.add),
    .s_csr_rd_i     (bus.rd),
    .s_csr_wr_i     (bus.wr),
    .s_csr_wdata_i  (bus.wdata),
    .s_csr_rdata_o  (bus.rdata),
    .s_csr_rvalid_o (bus.rvalid),
    .s_csr_hit_o    (bus.hit),
    .s_ovf_irq_o    (bus.ovf_irq)
  );

  // model state
  logic [63:0]   m_cnt [NC];
  logic [4:0]    m_sel [NC];
  logic [NC-1:0] m_inh;
  logic [NC-1:0] m_ovf;

  logic [31:0] exp_rdata;
  logic        exp_rvalid;
  logic        exp_irq;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a == 12'h320) v = 32'(m_inh) << 3;
    for (int i = 0; i < NC; i++) begin
      if (a == 12'h323 + 12'(i))
        v = {m_ovf[i], 26'b0, m_sel[i]};
      if (a == 12'hB03 + 12'(i))
        v = m_cnt[i][31:0];
      if (a == 12'hB83 + 12'(i))
        v = m_cnt[i][63:32];
    end
    return v;
  endfunction

  function automatic bit m_hit(input logic [11:0] a);
    bit h;
    h = (a == 12'h320);
    for (int i = 0; i < NC; i++) begin
      if (a == 12'h323 + 12'(i)) h = 1'b1;
      if (a == 12'hB03 + 12'(i)) h = 1'b1;
      if (a == 12'hB83 + 12'(i)) h = 1'b1;
    end
    return h;
  endfunction

  // Drive one cycle of stimulus and advance the model.
  task automatic step(
    input logic [11:0]   a,
    input bit            r,
    input bit            w,
    input logic [31:0]   d,
    input logic [NE-1:0] e,
    input bit            rs
  );
    logic [4:0] s;
    @(negedge clk);
    bus.add   = a;
    bus.rd    = r;
    bus.wr    = w;
    bus.wdata = d;
    ev        = e;
    rst       = rs;
    if (rs) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[i] = '0;
        m_sel[i] = '0;
      end
      m_inh      = '0;
      m_ovf      = '0;
      exp_rvalid = 1'b0;
      exp_rdata  = 32'h0;
    end else begin
      exp_rvalid = r;
      exp_rdata  = r ? m_read(a) : 32'h0;
      for (int i = 0; i < NC; i++) begin
        s = m_sel[i];
        if (w && a == 12'hB03 + 12'(i)) begin
          m_cnt[i] = {m_cnt[i][63:32], d};
        end else if (w && a == 12'hB83 + 12'(i)) begin
          m_cnt[i] = {d, m_cnt[i][31:0]} & MASK;
        end else begin
          if (w && a == 12'h323 + 12'(i)) begin
            m_sel[i] = d[4:0];
            if (OVF_EN) m_ovf[i] = d[31];
          end
          if (s >= 1 && s <= NE && e[s-1] && !m_inh[i]) begin
            m_cnt[i] = (m_cnt[i] + 64'd1) & MASK;
            if (OVF_EN && m_cnt[i] == 64'd0) m_ovf[i] = 1'b1;
          end
        end
      end
      if (w && a == 12'h320) m_inh = d[3 +: NC];
    end
    exp_irq = OVF_EN && (|m_ovf);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(12'h0, 1'b0, 1'b0, 32'h0, '0, 1'b1);
    step(12'h0, 1'b1, 1'b0, 32'h0, '1, 1'b1);
    n_cmp++;
    if (bus.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rvalid: got %0b want 0", bus.rvalid);
    end
    n_cmp++;
    if (bus.rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rst_rdata: got %h want 0", bus.rdata);
    end
    n_cmp++;
    if (bus.ovf_irq !== 1'b0) begin
      n_err++;
      $display("FAIL rst_irq: got %0b want 0", bus.ovf_irq);
    end
    for (int i = 0; i < NC; i++) begin
      step(12'hB03 + 12'(i), 1'b1, 1'b0, 32'h0, '0, 1'b0);
      n_cmp++;
      if (bus.rdata !== exp_rdata || bus.rvalid !== 1'b1) begin
        n_err++;
        $display("FAIL rst_cnt%0d: got %h/%0b want %h/1",
          i, bus.rdata, bus.rvalid, exp_rdata);
      end
    end
  endtask

  task automatic test_count();
    step(12'h323, 1'b0, 1'b1, 32'd2, '0, 1'b0);
    for (int k = 0; k < 5; k++)
      step(12'h0, 1'b0, 1'b0, 32'h0, 8'h02, 1'b0);
    step(12'hB03, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL count5: got %h/%0b want %h/1",
        bus.rdata, bus.rvalid, exp_rdata);
    end
    step(12'hB03, 1'b0, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rvalid !== exp_rvalid) begin
      n_err++;
      $display("FAIL idle_rvalid: got %0b want %0b",
        bus.rvalid, exp_rvalid);
    end
  endtask

  task automatic test_inhibit();
    step(12'h320, 1'b0, 1'b1, 32'h8, '0, 1'b0);
    for (int k = 0; k < 3; k++)
      step(12'h0, 1'b0, 1'b0, 32'h0, 8'h02, 1'b0);
    step(12'hB03, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL inhibit_hold: got %h want %h",
        bus.rdata, exp_rdata);
    end
    step(12'h320, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL inhibit_read: got %h want %h",
        bus.rdata, exp_rdata);
    end
    step(12'h320, 1'b0, 1'b1, 32'h0, '0, 1'b0);
    step(12'h0, 1'b0, 1'b0, 32'h0, 8'h02, 1'b0);
    step(12'hB03, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL inhibit_clear: got %h want %h",
        bus.rdata, exp_rdata);
    end
  endtask

  task automatic test_wrap();
    step(12'hB83, 1'b0, 1'b1, 32'hFF, '0, 1'b0);
    step(12'hB03, 1'b0, 1'b1, 32'hFFFF_FFFF, '0, 1'b0);
    step(12'h0, 1'b0, 1'b0, 32'h0, 8'h02, 1'b0);
    n_cmp++;
    if (bus.ovf_irq !== exp_irq) begin
      n_err++;
      $display("FAIL wrap_irq: got %0b want %0b",
        bus.ovf_irq, exp_irq);
    end
    step(12'hB03, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL wrap_lo: got %h want %h", bus.rdata, exp_rdata);
    end
    step(12'hB83, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL wrap_hi: got %h want %h", bus.rdata, exp_rdata);
    end
    step(12'h323, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL wrap_ovfbit: got %h want %h",
        bus.rdata, exp_rdata);
    end
    step(12'h323, 1'b0, 1'b1, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.ovf_irq !== exp_irq) begin
      n_err++;
      $display("FAIL wrap_irq_clr: got %0b want %0b",
        bus.ovf_irq, exp_irq);
    end
  endtask

  task automatic test_write_priority();
    step(12'h323, 1'b0, 1'b1, 32'd2, '0, 1'b0);
    step(12'hB03, 1'b0, 1'b1, 32'h100, 8'h02, 1'b0);
    step(12'hB03, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL wr_prio: got %h want %h", bus.rdata, exp_rdata);
    end
  endtask

  task automatic test_bad_sel();
    step(12'h324, 1'b0, 1'b1, 32'd9, '0, 1'b0);
    for (int k = 0; k < 4; k++)
      step(12'h0, 1'b0, 1'b0, 32'h0, 8'hFF, 1'b0);
    step(12'hB04, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL bad_sel: got %h want %h", bus.rdata, exp_rdata);
    end
    n_cmp++;
    if (bus.hit !== m_hit(12'hB04)) begin
      n_err++;
      $display("FAIL hit_impl: got %0b want 1", bus.hit);
    end
    step(12'h324, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL sel_read: got %h want %h", bus.rdata, exp_rdata);
    end
    step(12'h7FF, 1'b1, 1'b1, 32'hFFFF_FFFF, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata || bus.rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL unimpl_rd: got %h/%0b want %h/1",
        bus.rdata, bus.rvalid, exp_rdata);
    end
    n_cmp++;
    if (bus.hit !== m_hit(12'h7FF)) begin
      n_err++;
      $display("FAIL unimpl_hit: got %0b want 0", bus.hit);
    end
  endtask

  task automatic test_rdwr_same();
    step(12'hB05, 1'b1, 1'b1, 32'hABCD, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL rdwr_pre: got %h want %h", bus.rdata, exp_rdata);
    end
    step(12'hB05, 1'b1, 1'b0, 32'h0, '0, 1'b0);
    n_cmp++;
    if (bus.rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL rdwr_post: got %h want %h", bus.rdata, exp_rdata);
    end
  endtask

  task automatic test_random();
    logic [11:0]   a;
    logic [31:0]   d;
    logic [NE-1:0] e;
    bit            r, w, rs;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0: a = 12'h320;
        1: a = 12'h323 + 12'($urandom_range(0, NC - 1));
        2: a = 12'hB03 + 12'($urandom_range(0, NC - 1));
        3: a = 12'hB83 + 12'($urandom_range(0, NC - 1));
        4: a = 12'hB03 + 12'($urandom_range(0, NC));
        default: a = 12'($urandom);
      endcase
      d = $urandom;
      if ($urandom_range(0, 2) == 0) d = 32'hFFFF_FFFF;
      if (a[11:8] == 4'h3 && a != 12'h320)
        d = (d & 32'h8000_0000) | 32'($urandom_range(0, 9));
      if (a == 12'h320 && $urandom_range(0, 1) == 1) d = 32'h0;
      if (a[11:8] == 4'hB && a[7] && $urandom_range(0, 1) == 1)
        d = 32'hFF;
      r  = ($urandom_range(0, 1) == 1);
      w  = ($urandom_range(0, 3) == 0);
      e  = NE'($urandom);
      rs = ($urandom_range(0, 149) == 0);
      step(a, r, w, d, e, rs);
      n_cmp++;
      if (bus.rvalid !== exp_rvalid ||
          (exp_rvalid && bus.rdata !== exp_rdata)) begin
        n_err++;
        $display("FAIL rnd_rd @%0d a=%h: got %h/%0b want %h/%0b",
          n, a, bus.rdata, bus.rvalid, exp_rdata, exp_rvalid);
      end
      n_cmp++;
      if (bus.ovf_irq !== exp_irq) begin
        n_err++;
        $display("FAIL rnd_irq @%0d: got %0b want %0b",
          n, bus.ovf_irq, exp_irq);
      end
      n_cmp++;
      if (bus.hit !== m_hit(a)) begin
        n_err++;
        $display("FAIL rnd_hit @%0d a=%h: got %0b want %0b",
          n, a, bus.hit, m_hit(a));
      end
    end
  endtask

  task automatic test_reset_mid();
    step(12'h323, 1'b0, 1'b1, 32'd1, '0, 1'b0);
    step(12'hB83, 1'b0, 1'b1, 32'hFF, '0, 1'b0);
    step(12'hB03, 1'b0, 1'b1, 32'hFFFF_FFFE, '0, 1'b0);
    for (int k = 0; k < 3; k++)
      step(12'h0, 1'b0, 1'b0, 32'h0, 8'hFF, 1'b0);
    step(12'hB03, 1'b1, 1'b0, 32'h0, 8'hFF, 1'b1);
    n_cmp++;
    if (bus.rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_rvalid: got %0b want 0", bus.rvalid);
    end
    n_cmp++;
    if (bus.ovf_irq !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_irq: got %0b want 0", bus.ovf_irq);
    end
    for (int i = 0; i < NC; i++) begin
      step(12'hB03 + 12'(i), 1'b1, 1'b0, 32'h0, '0, 1'b0);
      n_cmp++;
      if (bus.rdata !== exp_rdata) begin
        n_err++;
        $display("FAIL rstmid_cnt%0d: got %h want %h",
          i, bus.rdata, exp_rdata);
      end
    end
  endtask

  initial begin
    bus.add   = '0;
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.wdata = '0;
    test_reset();
    test_count();
    test_inhibit();
    test_wrap();
    test_write_priority();
    test_bad_sel();
    test_rdwr_same();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
